// File: rtl/pio_event_master_pkg.sv
// Shared definitions for the PIO event master: slave register map, FSM states,
// and the event record width.
package pio_event_master_pkg;

  localparam int unsigned PIO_AW = 2;
  localparam int unsigned PIO_DW = 32;

  localparam logic [PIO_AW-1:0] ADDR_DATA = 2'd0;
  localparam logic [PIO_AW-1:0] ADDR_MASK = 2'd2;
  localparam logic [PIO_AW-1:0] ADDR_CAP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MASK,
    ST_RD_CAP,
    ST_WR_CLR,
    ST_RD_DATA,
    ST_PUSH
  } state_e;

  // Event record is {capture, data}, each WIDTH bits.
  function automatic int unsigned evt_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/pio_event_master_fifo.sv
// First-word-fall-through event FIFO; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module pio_evt_fifo #(
  parameter int unsigned DW    = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
  assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pio_event_master.sv
// Avalon-MM initiator that programs an edge-capture PIO's irq mask and, on
// irq, reads/clears the capture and reads live data into an event FIFO.
module pio_event_master
  import pio_event_master_pkg::*;
#(
  parameter int unsigned       WIDTH        = 10,
  parameter int unsigned       DEPTH        = 8,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [WIDTH-1:0]  MASK_INIT    = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [31:0]          pio_writedata,
  input  logic [31:0]          pio_readdata,
  input  logic                 pio_irq,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic                 cfg_mask_valid,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2*WIDTH-1:0]   evt_data,
  output logic                 evt_overflow,
  input  logic                 ovf_clr,
  output logic                 busy
);

  localparam int unsigned EW    = evt_width(WIDTH);
  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 2);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                read_done;

  logic [PIO_AW-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                wr_n_q, wr_n_d;
  logic [PIO_DW-1:0]   wdata_q, wdata_d;
  logic                busy_q;

  logic                mask_pend_q, mask_pend_d;
  logic [WIDTH-1:0]    mask_val_q, mask_val_d;
  logic [WIDTH-1:0]    cap_q, cap_d;
  logic [WIDTH-1:0]    dat_q, dat_d;
  logic                push_q, push_d;
  logic                ovf_q, ovf_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                drop;
  logic [EW-1:0]       fifo_rdata;
  logic                unused_rdata;

  assign unused_rdata = ^pio_readdata[PIO_DW-1:WIDTH];

  // Reads hold the address for READ_LATENCY+1 cycles; sample on the last one.
  assign read_done = (cnt_q == CNT_W'(READ_LATENCY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (mask_pend_q)  state_d = ST_WR_MASK;
        else if (pio_irq) state_d = ST_RD_CAP;
      end
      ST_WR_MASK: state_d = ST_IDLE;
      ST_RD_CAP: begin
        if (read_done) state_d = ST_WR_CLR;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WR_CLR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (read_done) state_d = ST_PUSH;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PUSH: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus registers load from the next state so the access is visible in-state.
  always_comb begin
    cs_d        = 1'b0;
    wr_n_d      = 1'b1;
    addr_d      = ADDR_DATA;
    wdata_d     = '0;
    cap_d       = cap_q;
    dat_d       = dat_q;
    push_d      = 1'b0;
    mask_pend_d = mask_pend_q;
    mask_val_d  = mask_val_q;
    case (state_d)
      ST_WR_MASK: begin
        cs_d    = 1'b1;
        wr_n_d  = 1'b0;
        addr_d  = ADDR_MASK;
        wdata_d = PIO_DW'(mask_val_q);
      end
      ST_RD_CAP: begin
        cs_d   = 1'b1;
        addr_d = ADDR_CAP;
      end
      ST_WR_CLR: begin
        cs_d   = 1'b1;
        wr_n_d = 1'b0;
        addr_d = ADDR_CAP;
      end
      ST_RD_DATA: begin
        cs_d   = 1'b1;
        addr_d = ADDR_DATA;
      end
      default: ;
    endcase
    if (state_q == ST_RD_CAP && read_done)  cap_d = pio_readdata[WIDTH-1:0];
    if (state_q == ST_RD_DATA && read_done) dat_d = pio_readdata[WIDTH-1:0];
    if (state_q == ST_PUSH)                 push_d = (cap_q != '0);
    if (state_q == ST_IDLE && state_d == ST_WR_MASK) mask_pend_d = 1'b0;
    // A new request always re-arms, even while the previous value is on the bus.
    if (cfg_mask_valid) begin
      mask_pend_d = 1'b1;
      mask_val_d  = cfg_mask;
    end
  end

  assign fifo_pop = evt_valid && evt_ready;
  assign drop     = push_q && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b1;
      mask_pend_q <= 1'b1;
      mask_val_q  <= MASK_INIT;
      cap_q       <= '0;
      dat_q       <= '0;
      push_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      wr_n_q      <= wr_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= (state_d != ST_IDLE);
      mask_pend_q <= mask_pend_d;
      mask_val_q  <= mask_val_d;
      cap_q       <= cap_d;
      dat_q       <= dat_d;
      push_q      <= push_d;
      ovf_q       <= ovf_d;
    end
  end

  pio_evt_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push_q),
    .pop_i   (fifo_pop),
    .wdata_i ({cap_q, dat_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wr_n_q;
  assign pio_writedata  = wdata_q;
  assign busy           = busy_q;
  assign evt_valid      = !fifo_empty;
  assign evt_data       = fifo_rdata;
  assign evt_overflow   = ovf_q;

endmodule

// File: tb/tb_pio_event_master.sv
// Bench for pio_event_master: behavioural PIO slave, bus transaction log and
// a queue-based event model.
`timescale 1ns/1ps
module tb_pio_event_master;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned EW    = 2 * WIDTH;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  len;
  } bus_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata = '0;
  logic             pio_irq;
  logic [WIDTH-1:0] cfg_mask = '0;
  logic             cfg_mask_valid = 1'b0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [EW-1:0]    evt_data;
  logic             evt_overflow;
  logic             ovf_clr = 1'b0;
  logic             busy;

  logic [WIDTH-1:0] s_cap = '0;
  logic [WIDTH-1:0] s_mask = '0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] inj_cap = '0;
  logic             irq_force = 1'b0;

  bus_t          bus_log[$];
  bus_t          exp_log[$];
  bit            prev_rd = 1'b0;
  logic [1:0]    prev_addr = '0;
  int            mon_last;
  logic [EW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_fail = 0;

  pio_event_master #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .READ_LATENCY (1),
    .MASK_INIT    ({WIDTH{1'b1}})
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .pio_irq        (pio_irq),
    .cfg_mask       (cfg_mask),
    .cfg_mask_valid (cfg_mask_valid),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_overflow   (evt_overflow),
    .ovf_clr        (ovf_clr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic bus_t mk(input logic wr, input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] len);
    bus_t b;
    b.wr = wr; b.addr = a; b.data = d; b.len = len;
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] rd_val(input logic [1:0] a);
    case (a)
      2'd0:    return sw;
      2'd2:    return s_mask;
      2'd3:    return s_cap;
      default: return '0;
    endcase
  endfunction

  // Edge-capture PIO slave: registered read data with junk in the upper bits.
  assign pio_irq = (|(s_cap & s_mask)) | irq_force;

  always @(posedge clk) begin
    if (pio_chipselect && pio_write_n) pio_readdata <= {22'h2AAAAA, rd_val(pio_address)};
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) s_cap <= '0;
    else s_cap <= s_cap | inj_cap;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) s_mask <= pio_writedata[WIDTH-1:0];
  end

  // Bus monitor: one log entry per access, reads carry their hold length.
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) begin
      bus_log.push_back(mk(1'b1, pio_address, pio_writedata, 4'd1));
      prev_rd = 1'b0;
    end else if (pio_chipselect) begin
      if (prev_rd && prev_addr == pio_address) begin
        mon_last = bus_log.size() - 1;
        bus_log[mon_last].len = bus_log[mon_last].len + 4'd1;
      end else begin
        bus_log.push_back(mk(1'b0, pio_address, 32'h0, 4'd1));
      end
      prev_rd   = 1'b1;
      prev_addr = pio_address;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int run = 0;
    int budget = 0;
    while (run < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      run = busy ? 0 : run + 1;
    end
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic inject(input logic [WIDTH-1:0] cap, input logic [WIDTH-1:0] dat);
    @(negedge clk);
    sw      = dat;
    inj_cap = cap;
    @(negedge clk);
    inj_cap = '0;
  endtask

  task automatic model_push(input logic [WIDTH-1:0] cap, input logic [WIDTH-1:0] dat);
    if (cap != '0) begin
      if (model_q.size() < DEPTH) model_q.push_back({cap, dat});
      else model_ovf = 1'b1;
    end
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_count"}, 64'(bus_log.size() - base), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      if (base + i < bus_log.size())
        chk({tag, "_entry"}, 64'(bus_log[base + i]), 64'(exp_log[i]));
    exp_log.delete();
  endtask

  task automatic exp_service();
    exp_log.push_back(mk(1'b0, 2'd3, 32'h0, 4'd2));
    exp_log.push_back(mk(1'b1, 2'd3, 32'h0, 4'd1));
    exp_log.push_back(mk(1'b0, 2'd0, 32'h0, 4'd2));
  endtask

  task automatic wait_bus(input logic wr, input logic [1:0] a);
    int budget = 0;
    while (!(pio_chipselect && (pio_write_n == !wr) && pio_address == a) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("bus_wait", 64'(pio_chipselect), 64'(1));
  endtask

  task automatic drain();
    int guard = 0;
    while (model_q.size() > 0 && guard < 64) begin
      chk("drain_valid", 64'(evt_valid), 64'(1));
      chk("drain_data", 64'(evt_data), 64'(model_q[0]));
      void'(model_q.pop_front());
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      guard++;
    end
    chk("drain_empty", 64'(evt_valid), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;

    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_cs", 64'(pio_chipselect), 64'(0));
    chk("rst_write_n", 64'(pio_write_n), 64'(1));
    chk("rst_addr", 64'(pio_address), 64'(0));
    chk("rst_wdata", 64'(pio_writedata), 64'(0));
    chk("rst_evt_valid", 64'(evt_valid), 64'(0));
    chk("rst_ovf", 64'(evt_overflow), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Initial mask write
    base = bus_log.size();
    wait_idle();
    exp_log.push_back(mk(1'b1, 2'd2, 32'h3FF, 4'd1));
    check_log("init_mask", base);
    chk("init_slave_mask", 64'(s_mask), 64'h3FF);

    // Single event and its latency
    base = bus_log.size();
    inject(10'h004, 10'h005);
    n = 0;
    while (!evt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(8));
    chk("evt1_data", 64'(evt_data), 64'h01005);
    wait_idle();
    chk("evt1_cap_cleared", 64'(s_cap), 64'(0));
    exp_service();
    check_log("evt1_bus", base);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("evt1_popped", 64'(evt_valid), 64'(0));

    // Mask request during RD_DATA with a second irq pending
    base = bus_log.size();
    inject(10'h010, 10'h00A);
    wait_bus(1'b0, 2'd0);
    cfg_mask       = 10'h00F;
    cfg_mask_valid = 1'b1;
    inj_cap        = 10'h002;
    @(negedge clk);
    cfg_mask_valid = 1'b0;
    inj_cap        = '0;
    wait_idle();
    exp_service();
    exp_log.push_back(mk(1'b1, 2'd2, 32'h00F, 4'd1));
    exp_service();
    check_log("mask_mid", base);
    chk("mask_mid_slave", 64'(s_mask), 64'h00F);
    model_q.push_back({10'h010, 10'h00A});
    model_q.push_back({10'h002, 10'h00A});
    drain();

    // Spurious irq
    base = bus_log.size();
    @(negedge clk);
    irq_force = 1'b1;
    @(negedge clk);
    irq_force = 1'b0;
    wait_idle();
    exp_service();
    check_log("spurious", base);
    chk("spurious_no_evt", 64'(evt_valid), 64'(0));

    // Restore full mask
    @(negedge clk);
    cfg_mask       = 10'h3FF;
    cfg_mask_valid = 1'b1;
    @(negedge clk);
    cfg_mask_valid = 1'b0;
    wait_idle();
    chk("mask_restore", 64'(s_mask), 64'h3FF);

    // Fill past DEPTH; last drop coincides with an ovf_clr pulse
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = WIDTH'($urandom_range(1, 1023));
      d = WIDTH'($urandom);
      inject(c, d);
      if (i == DEPTH) begin
        repeat (7) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
      end
      model_push(c, d);
      wait_idle();
    end
    chk("ovf_set", 64'(evt_overflow), 64'(model_ovf));
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    chk("ovf_cleared", 64'(evt_overflow), 64'(0));

    // Push on full with a simultaneous pop
    c = WIDTH'($urandom_range(1, 1023));
    d = WIDTH'($urandom);
    inject(c, d);
    repeat (7) @(negedge clk);
    evt_ready = 1'b1;
    chk("full_pop_data", 64'(evt_data), 64'(model_q[0]));
    void'(model_q.pop_front());
    model_q.push_back({c, d});
    @(negedge clk);
    evt_ready = 1'b0;
    wait_idle();
    chk("full_pop_no_ovf", 64'(evt_overflow), 64'(0));
    drain();

    // Random events with a randomly stalling consumer
    for (int i = 0; i < 12; i++) begin
      c = WIDTH'($urandom_range(1, 1023));
      d = WIDTH'($urandom);
      inject(c, d);
      model_push(c, d);
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        evt_ready = 1'($urandom_range(0, 1));
        if (evt_valid && evt_ready) begin
          chk("rand_data", 64'(evt_data), 64'(model_q[0]));
          void'(model_q.pop_front());
        end
      end
      evt_ready = 1'b0;
    end
    chk("rand_ovf", 64'(evt_overflow), 64'(model_ovf));
    drain();

    // Reset during WR_CLR
    c = WIDTH'($urandom_range(1, 1023));
    d = WIDTH'($urandom);
    inject(c, d);
    wait_idle();
    chk("pre_rst_valid", 64'(evt_valid), 64'(1));
    c = WIDTH'($urandom_range(1, 1023));
    d = WIDTH'($urandom);
    inject(c, d);
    wait_bus(1'b1, 2'd3);
    reset = 1'b1;
    #1;
    chk("midrst_cs", 64'(pio_chipselect), 64'(0));
    chk("midrst_write_n", 64'(pio_write_n), 64'(1));
    chk("midrst_fifo_empty", 64'(evt_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    base = bus_log.size();
    wait_idle();
    chk("midrst_log_nonempty", 64'(bus_log.size() > base), 64'(1));
    if (bus_log.size() > base)
      chk("midrst_mask_rewrite", 64'(bus_log[base]), 64'(mk(1'b1, 2'd2, 32'h3FF, 4'd1)));
    model_q.delete();
    model_q.push_back({c, d});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pio_event_master.md
Name: pio_event_master

Overview:
- Avalon-MM initiator that services an edge-capturing input PIO slave (address map: 0 = data, 2 = irq mask, 3 = edge capture; any write to address 3 clears the capture).
- Programs the slave's irq mask.
- On pio_irq it reads the capture register, clears it, then reads the live data.
- Pushes a {capture, data} event record into a local FIFO, so downstream logic consumes switch/button events without a CPU.

Parameters:
- WIDTH, 10, number of PIO input bits.
- DEPTH, 8, event FIFO depth in entries (power of two, ≥2).
- READ_LATENCY, 1, cycles from stable address to valid pio_readdata.
- MASK_INIT, all-ones (WIDTH bits), irq mask written automatically after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- pio_address  out  2  slave word address
- pio_chipselect  out  1  slave select
- pio_write_n  out  1  active-low write strobe
- pio_writedata  out  32  write data
- pio_readdata  in  32  registered slave read data
- pio_irq  in  1  slave interrupt (level)
- cfg_mask  in  WIDTH  new irq mask value
- cfg_mask_valid  in  1  one-cycle pulse requesting a mask write
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pop (valid & ready)
- evt_data  out  2*WIDTH  {capture[WIDTH-1:0], data[WIDTH-1:0]} at FIFO head
- evt_overflow  out  1  sticky, event dropped because the FIFO was full
- ovf_clr  in  1  clears evt_overflow
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high) values:
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - evt_valid=0, evt_overflow=0, busy=1.
  - FIFO empty.
  - Mask-pending flag set with the MASK_INIT value.
  - FSM enters IDLE.
- All bus outputs are registered.
- Bus access rules:
  - Reads: chipselect=1, write_n=1, address held for READ_LATENCY+1 cycles; pio_readdata[WIDTH-1:0] is sampled on the final cycle.
  - Writes: chipselect=1, write_n=0 for exactly one cycle.
  - Unused writedata bits are 0.
- FSM states: IDLE, WR_MASK, RD_CAP, WR_CLR, RD_DATA, PUSH.
- IDLE transitions:
  - Mask pending → WR_MASK. Mask writes take priority over irq service.
  - Else pio_irq=1 → RD_CAP.
  - busy=0 only in IDLE.
- WR_MASK: address 2, writedata={0, mask}; clears the pending flag; → IDLE.
- cfg_mask_valid handling:
  - Accepted in any state; overwrites the pending value (last request wins).
  - A pulse arriving during WR_MASK re-arms pending with the new value.
- RD_CAP: address 3; captured value stored as cap; → WR_CLR.
- WR_CLR: address 3, writedata=0.
  - Clears the capture immediately after reading it, to minimise the lost-edge window.
  - Edges the slave latches between the RD_CAP sample and this write are lost (accepted).
  - → RD_DATA.
- RD_DATA: address 0; sampled value stored as dat; → PUSH.
- PUSH: one cycle.
  - cap==0 (spurious irq): no push.
  - Else FIFO not full: push {cap, dat}.
  - Else FIFO full: drop the event and set evt_overflow.
  - → IDLE.
- Stale irq: the slave deasserts pio_irq one cycle after WR_CLR. The RD_DATA+PUSH path is ≥3 cycles, so IDLE never re-triggers on a stale irq.
- evt_overflow:
  - Set in the PUSH-drop case; held until ovf_clr.
  - Set and ovf_clr in the same cycle: set wins.
- FIFO:
  - First-word-fall-through; evt_data is valid whenever evt_valid=1.
  - Push and pop in the same cycle: both occur, occupancy unchanged.
  - Push on full with simultaneous pop: accepted, no overflow.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Latency, READ_LATENCY=1: irq seen in IDLE → evt_valid high 8 cycles later (RD_CAP 2, WR_CLR 1, RD_DATA 2, PUSH 1, FIFO write 1, plus IDLE decision).
- Reset mid-transaction: the bus returns to idle asynchronously, the FIFO is flushed, and the MASK_INIT write is re-issued.

Decomposition:
- Shared package:
  - PIO register addresses (ADDR_DATA=0, ADDR_MASK=2, ADDR_CAP=3).
  - FSM state enum.
  - Event record width function.
- Sub-module pio_evt_fifo: parameterised synchronous FWFT FIFO with push, pop, full, empty, async active-high reset.

Test Plan (WIDTH=10, READ_LATENCY=1):
- Release reset, slave model idle → a single write to address 2 with writedata=0x3FF; then idle, busy=0.
- Slave capture=0x004, data=0x005, irq pulse → bus sequence is read 3, write 3, read 0. Then evt_data=0x01005 (cap 0x004 in the upper WIDTH bits, data 0x005 in the lower) with evt_valid=1, and the slave capture register equals 0 afterward.
- cfg_mask_valid with cfg_mask=0x00F while in RD_DATA → no bus glitch; a mask write of 0x00F is issued right after PUSH, before servicing a still-pending irq.
- Spurious irq with capture=0 → read 3, write 3, read 0 occur; no FIFO push; evt_valid stays 0.
- evt_ready=0 and 9 events injected → the first 8 are stored; the 9th sets evt_overflow=1. Popping all 8 returns them in order. ovf_clr → evt_overflow=0.
- Reset asserted during WR_CLR → chipselect=0 and write_n=1 immediately, FIFO empty. After release, the MASK_INIT write is issued again.
